// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with a stale-fetch discard FSM.
// Optional stall watchdog is compiled in when STALL_WDT_EN is defined.
`ifndef STAGE_NUM
`define STAGE_NUM 5
`endif
`ifndef IF_STAGE
`define IF_STAGE 0
`endif
`ifndef ID_STAGE
`define ID_STAGE 1
`endif
`ifndef EX_STAGE
`define EX_STAGE 2
`endif
`ifndef ME_STAGE
`define ME_STAGE 3
`endif
`ifndef WB_STAGE
`define WB_STAGE 4
`endif

module pipe_hazard_ctrl #(
    parameter int WDT_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  im_busy,
    input  logic                  dm_busy,
    input  logic                  load_use,
    input  logic                  ex_branch_taken,
    output logic [`STAGE_NUM-1:0] stall,
    output logic [`STAGE_NUM-1:0] flush,
    output logic                  pc_redirect,
    output logic                  discard_busy,
    output logic                  wdt_timeout
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam logic [`STAGE_NUM-1:0] HOLD_NONE = 5'b00000;
    localparam logic [`STAGE_NUM-1:0] HOLD_IF   = 5'b00001;
    localparam logic [`STAGE_NUM-1:0] HOLD_ID   = 5'b00011;
    localparam logic [`STAGE_NUM-1:0] HOLD_ME   = 5'b01111;

    state_t                  state_r;
    logic                    discard_busy_r;
    logic [`STAGE_NUM-1:0]   stall_s;
    logic [`STAGE_NUM-1:0]   flush_s;
    logic                    redirect_s;
    logic                    enter_discard_s;

    // Hazard priority decode; outputs are forced quiet while reset is held
    always_comb begin
        stall_s         = HOLD_NONE;
        flush_s         = HOLD_NONE;
        redirect_s      = 1'b0;
        enter_discard_s = 1'b0;
        if (rst) begin
            stall_s = HOLD_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dm_busy) begin
                        stall_s = HOLD_ME;
                    end else if (ex_branch_taken) begin
                        redirect_s               = 1'b1;
                        flush_s[`ID_STAGE]       = 1'b1;
                        flush_s[`EX_STAGE]       = 1'b1;
                        enter_discard_s          = im_busy;
                    end else if (load_use) begin
                        stall_s = HOLD_ID;
                    end else if (im_busy) begin
                        stall_s = HOLD_IF;
                    end else begin
                        stall_s = HOLD_NONE;
                    end
                end
                DISCARD: begin
                    // The stale fetch is killed in ID; a late branch request is ignored
                    stall_s            = dm_busy ? HOLD_ME : HOLD_IF;
                    flush_s[`ID_STAGE] = 1'b1;
                end
                default: begin
                    stall_s = HOLD_NONE;
                end
            endcase
        end
    end

    // Discard FSM with registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            discard_busy_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enter_discard_s) begin
                        state_r        <= DISCARD;
                        discard_busy_r <= 1'b1;
                    end else begin
                        state_r        <= IDLE;
                        discard_busy_r <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (!im_busy) begin
                        state_r        <= IDLE;
                        discard_busy_r <= 1'b0;
                    end else begin
                        state_r        <= DISCARD;
                        discard_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    discard_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall        = stall_s;
    assign flush        = flush_s;
    assign pc_redirect  = redirect_s;
    assign discard_busy = discard_busy_r;

`ifdef STALL_WDT_EN
    localparam int CW = $clog2(WDT_LIMIT + 1);

    logic [CW-1:0] wdt_cnt_r;
    logic [CW-1:0] wdt_cnt_nxt_s;
    logic          wdt_timeout_r;

    // Saturating run-length of consecutive fetch stalls
    always_comb begin
        wdt_cnt_nxt_s = wdt_cnt_r;
        if (!stall_s[`IF_STAGE]) begin
            wdt_cnt_nxt_s = {CW{1'b0}};
        end else if (wdt_cnt_r == CW'(WDT_LIMIT)) begin
            wdt_cnt_nxt_s = wdt_cnt_r;
        end else begin
            wdt_cnt_nxt_s = wdt_cnt_r + CW'(1);
        end
    end

    // Counter register and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt_r     <= {CW{1'b0}};
            wdt_timeout_r <= 1'b0;
        end else begin
            wdt_cnt_r <= wdt_cnt_nxt_s;
            if (wdt_cnt_nxt_s == CW'(WDT_LIMIT)) begin
                wdt_timeout_r <= 1'b1;
            end else begin
                wdt_timeout_r <= wdt_timeout_r;
            end
        end
    end

    assign wdt_timeout = wdt_timeout_r;
`else
    localparam int wdt_limit_unused = WDT_LIMIT;
    assign wdt_timeout = 1'b0;
`endif

endmodule
